// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between the fetch and data ports. Data port has priority; with
// MEM_ARB_STARVE_GUARD_EN defined, a starvation counter forces one fetch grant.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    logic i_force_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_r;

    assign i_force_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

    // Count data wins taken while the fetch port waits; any fetch grant or idle fetch port clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (i_gnt || !i_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (d_gnt) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign i_force_s = 1'b0;
`endif

    // One grant per cycle: data wins unless the fetch port has been starved long enough.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (d_req && !(i_req && i_force_s)) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            i_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single 1-cycle-latency memory.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    resp_state_e       state_r;
    resp_state_e       state_next_s;
    logic              wen_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              i_req_s;
    logic              d_req_s;

    // Requests are masked while reset is held so no grant or strobe escapes.
    assign i_req_s = i_req & ~rst;
    assign d_req_s = d_req & ~rst;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .i_req (i_req_s),
        .d_req (d_req_s),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    assign mem_en    = i_gnt | d_gnt;
    assign mem_wen   = d_gnt & d_wen;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;

    // Response FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state tracks this cycle's grant; rvalid flags decode the current state.
    always_comb begin
        state_next_s = IDLE;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        if (i_gnt) begin
            state_next_s = RESP_I;
        end else if (d_gnt) begin
            state_next_s = RESP_D;
        end else begin
            state_next_s = IDLE;
        end
        case (state_r)
            RESP_I:  i_rvalid = 1'b1;
            RESP_D:  d_rvalid = 1'b1;
            default: begin
                i_rvalid = 1'b0;
                d_rvalid = 1'b0;
            end
        endcase
    end

    // Latch the data access direction and capture returning read data per port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_r     <= 1'b0;
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (d_gnt) begin
                wen_r <= d_wen;
            end else begin
                wen_r <= wen_r;
            end
            if (state_r == RESP_I) begin
                i_rdata_r <= mem_rdata;
            end else begin
                i_rdata_r <= i_rdata_r;
            end
            if ((state_r == RESP_D) && !wen_r) begin
                d_rdata_r <= mem_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // Present memory data alongside rvalid; hold the captured value otherwise.
    always_comb begin
        i_rdata = i_rdata_r;
        d_rdata = d_rdata_r;
        if (state_r == RESP_I) begin
            i_rdata = mem_rdata;
        end else begin
            i_rdata = i_rdata_r;
        end
        if ((state_r == RESP_D) && !wen_r) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = d_rdata_r;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus starvation and reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_wen;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Word memory, preloaded so that each word reads back as its byte address + 1.
    logic [31:0] mem_arr [0:255];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) mem_arr[mem_addr[9:2]] <= mem_wdata;
            else         mem_rdata <= mem_arr[mem_addr[9:2]];
        end
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          port_d;
        bit          is_read;
        logic [31:0] data;
    } resp_t;
    resp_t       sb[$];
    logic [31:0] i_hold, d_hold;

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dd;
        bit          eg_i;
        bit          eg_d;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        resp_t e;
        bit    ev_i = 1'b0;
        bit    ev_d = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port_d) begin
                ev_d = 1'b1;
                if (e.is_read) d_hold = e.data;
            end else begin
                ev_i   = 1'b1;
                i_hold = e.data;
            end
        end
        chk("i_rvalid", 32'(i_rvalid), 32'(ev_i));
        chk("d_rvalid", 32'(d_rvalid), 32'(ev_d));
        chk("i_rdata", i_rdata, i_hold);
        chk("d_rdata", d_rdata, d_hold);
    endtask

    task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd,
                         input bit eg_i, input bit eg_d);
        resp_t r;
        i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
        #1;
        chk("i_gnt", 32'(i_gnt), 32'(eg_i));
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("mem_en", 32'(mem_en), 32'(eg_i | eg_d));
        chk("mem_wen", 32'(mem_wen), 32'(eg_d & dw));
        if (eg_d) begin
            chk("mem_addr_d", mem_addr, da);
            if (dw) chk("mem_wdata", mem_wdata, dd);
            r.port_d = 1'b1; r.is_read = !dw; r.data = dw ? 32'h0 : mem_arr[da[9:2]];
            sb.push_back(r);
        end else if (eg_i) begin
            chk("mem_addr_i", mem_addr, ia);
            r.port_d = 1'b0; r.is_read = 1'b1; r.data = mem_arr[ia[9:2]];
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        check_resp();
    endtask

    initial begin
        bit guard;
`ifdef MEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        for (int k = 0; k < 256; k++) mem_arr[k] = 32'(k * 4 + 1);
        i_hold = 32'h0;
        d_hold = 32'h0;

        //            ir    ia        dr    dw    da        dd            eg_i  eg_d
        vt[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0, 1'b1};
        vt[5]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b1};
        vt[6]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[7]  = '{1'b1, 32'h30, 1'b1, 1'b1, 32'h44, 32'h12345678, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 32'h30, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b1};
        vt[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0};
        vt[11] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
        vt[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0};

        // Reset with both requests high: nothing may be granted or strobed.
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_wen = 1'b1;
        i_addr = 32'h10; d_addr = 32'h40; d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_gnt", 32'(i_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_wen", 32'(mem_wen), 32'h0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 13; v++)
            cycle(vt[v].ir, vt[v].ia, vt[v].dr, vt[v].dw, vt[v].da, vt[v].dd, vt[v].eg_i, vt[v].eg_d);

        // Both ports held for ten cycles: data only, or D,D,D,D,I with the guard.
        for (int k = 0; k < 10; k++) begin
            bit exp_i;
            exp_i = guard && ((k % 5) == 4);
            cycle(1'b1, 32'h90, 1'b1, 1'b0, 32'h80, 32'h0, exp_i, !exp_i);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset lands while a data read response is outstanding.
        i_req = 1'b0; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h44;
        #1;
        chk("pre_rst_d_gnt", 32'(d_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("mid_rst_d_rdata", d_rdata, 32'h0);
        chk("mid_rst_i_rdata", i_rdata, 32'h0);
        chk("mid_rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'h0);
        sb.delete();
        i_hold = 32'h0;
        d_hold = 32'h0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("post_rst_i_rvalid", 32'(i_rvalid), 32'h0);
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
